alu_issue_ctrl: RTL

- Initiator/sequencer for the combinational 20-bit ALU. Accepts one operation request at a time, reads operands from a local register file, and drives the ALU's instruction/A/B inputs.
- Captures the ALU result and carry, then writes back the result or updates the status flags.
- Implements the ops the ALU itself leaves out (SWAP, INC, DEC, EQ/GT/LT/GET/LET) by sequencing the ALU, and holds the status register (Z, N, C).

---
 rtl/alu_issue_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the 20-bit combinational ALU: regfile, Z/N/C status, and
// the multi-step ops the ALU lacks. Define ALU_OP_COUNT_EN to build the op counter.
module alu_issue_ctrl #(
  parameter int DATA_W = 20,
  parameter int OP_W   = 14,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic [ADDR_W-1:0] req_ra,
  input  logic [ADDR_W-1:0] req_rb,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_err,
  output logic [OP_W-1:0]   alu_instruction,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry_out,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       op_count
);
  localparam logic [OP_W-1:0] OP_NOT = 'h0A7, OP_OR = 'h0D1, OP_AND = 'h0BC, OP_XOR = 'h0E6,
    OP_SHR = 'h0FB, OP_SHL = 'h110, OP_ROR = 'h125, OP_ROL = 'h13A, OP_SWAP = 'h14F,
    OP_INC = 'h164, OP_DEC = 'h179, OP_ADD = 'h18E, OP_ADDC = 'h1A3, OP_SUB = 'h1B8,
    OP_SUBC = 'h1CD, OP_EQ = 'h1E2, OP_GT = 'h1F7, OP_LT = 'h20C, OP_GET = 'h221, OP_LET = 'h236;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_WB2} state_t;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q;
  logic [ADDR_W-1:0]   rd_q, ra_q, rb_q;
  logic [DATA_W-1:0]   opa_q, opb_q, res_q;
  logic                carry_q;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic                z_q, n_q, c_q, z_d, n_d, c_d;

  logic                is_wr, is_cmp, is_swap, is_carry, is_incdec, is_legal;
  logic                wb_we;
  logic [ADDR_W-1:0]   wb_addr;
  logic [DATA_W-1:0]   wb_data;

  always_comb begin
    is_wr = 1'b0; is_cmp = 1'b0; is_swap = 1'b0; is_carry = 1'b0; is_incdec = 1'b0;
    case (op_q)
      OP_NOT, OP_OR, OP_AND, OP_XOR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_ADD, OP_SUB:                        is_wr = 1'b1;
      OP_ADDC, OP_SUBC:                      begin is_wr = 1'b1; is_carry = 1'b1; end
      OP_INC, OP_DEC:                        begin is_wr = 1'b1; is_incdec = 1'b1; end
      OP_EQ, OP_GT, OP_LT, OP_GET, OP_LET:   is_cmp = 1'b1;
      OP_SWAP:                               is_swap = 1'b1;
      default: ;
    endcase
    is_legal = is_wr | is_cmp | is_swap;
  end

  always_comb begin
    state_d = state_q;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_result = '0; rsp_err = 1'b0;
    alu_instruction = '0; alu_a = '0; alu_b = '0;
    wb_we = 1'b0; wb_addr = rd_q; wb_data = res_q;
    z_d = z_q; n_d = n_q; c_d = c_q;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_a = opa_q;
        alu_b = is_incdec ? {{(DATA_W-1){1'b0}}, 1'b1} : opb_q;
        if (op_q == OP_INC)                 alu_instruction = OP_ADD;
        else if (op_q == OP_DEC || is_cmp)  alu_instruction = OP_SUB;
        else if (is_wr)                     alu_instruction = op_q;
        state_d = S_WB;
      end
      S_WB: begin
        if (is_swap) begin
          wb_we = 1'b1; wb_addr = ra_q; wb_data = opb_q;
          state_d = S_WB2;
        end else begin
          rsp_valid  = 1'b1;
          rsp_result = is_wr ? res_q : '0;
          rsp_err    = ~is_legal;
          wb_we      = is_wr;
          if (is_carry) c_d = carry_q;
          // Compares judge the latched operands directly; the ALU SUB output is unused.
          case (op_q)
            OP_EQ:  z_d = (opa_q == opb_q);
            OP_GT:  n_d = (opa_q > opb_q);
            OP_LT:  n_d = (opa_q < opb_q);
            OP_GET: begin z_d = (opa_q >= opb_q); n_d = ~(opa_q >= opb_q); end
            OP_LET: begin z_d = (opa_q <= opb_q); n_d = (opa_q <= opb_q); end
            default: ;
          endcase
          state_d = S_IDLE;
        end
      end
      S_WB2: begin
        wb_we = 1'b1; wb_addr = rb_q; wb_data = opa_q;
        rsp_valid = 1'b1; rsp_result = opa_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q <= '0; rd_q <= '0; ra_q <= '0; rb_q <= '0;
      opa_q <= '0; opb_q <= '0; res_q <= '0; carry_q <= 1'b0;
      z_q <= 1'b0; n_q <= 1'b0; c_q <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q <= z_d; n_q <= n_d; c_q <= c_d;
      if (state_q == S_IDLE && req_valid) begin
        op_q <= req_op; rd_q <= req_rd; ra_q <= req_ra; rb_q <= req_rb;
        opa_q <= regs_q[req_ra]; opb_q <= regs_q[req_rb];
      end
      if (state_q == S_EXEC) begin
        res_q <= alu_result;
        if (is_carry) carry_q <= alu_carry_out;
      end
    end
  end

  // Write-back beats a same-address host write in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (!rst_n)                                    regs_q[i] <= '0;
      else if (wb_we && wb_addr == ADDR_W'(i))       regs_q[i] <= wb_data;
      else if (host_we && host_addr == ADDR_W'(i))   regs_q[i] <= host_wdata;
    end
  end

  assign dbg_data = regs_q[dbg_addr];
  assign flag_z = z_q;
  assign flag_n = n_q;
  assign flag_c = c_q;

`ifdef ALU_OP_COUNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else if (rsp_valid && !rsp_err && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
  assign op_count = cnt_q;
`else
  assign op_count = '0;
`endif
endmodule
